// File: rtl/uart_rx_os.sv
// 8N1 UART receiver with 16x oversampling: two-flop line synchroniser, start-bit
// validation and 2-of-3 majority vote on the mid-bit samples (s = 7, 8, 9).
module uart_rx_os #(
  parameter int freq      = 100_000_000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_out,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int OSR_DIV = freq / (baud_rate * 16);
  localparam int CNT_W   = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic             rx_meta;
  logic             rx_s;
  logic [CNT_W-1:0] osr_cnt;
  logic             tick;
  state_t           state;
  logic [3:0]       s_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [2:0]       smp;
  logic             vote;
  logic             vote_stop;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign tick      = (osr_cnt == CNT_W'(OSR_DIV - 1));
  assign vote      = maj3(smp[0], smp[1], smp[2]);
  // STOP decides on the s=9 tick itself, so the third sample is taken straight from rx_s
  assign vote_stop = maj3(smp[0], smp[1], rx_s);

  // line synchroniser, idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // free-running oversample tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      osr_cnt <= '0;
    end else if (tick) begin
      osr_cnt <= '0;
    end else begin
      osr_cnt <= osr_cnt + 1'b1;
    end
  end

  // mid-bit samples and shift register: data only, no reset
  always_ff @(posedge clk) begin
    if (tick && state != IDLE) begin
      case (s_cnt)
        4'd7:    smp[0] <= rx_s;
        4'd8:    smp[1] <= rx_s;
        4'd9:    smp[2] <= rx_s;
        default: ;
      endcase
      if (state == DATA && s_cnt == 4'd15) begin
        shreg <= {vote, shreg[7:1]};
      end
    end
  end

  // receive FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      s_cnt     <= 4'd0;
      bit_cnt   <= 3'd0;
      rx_out    <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state   <= START;
              s_cnt   <= 4'd0;
              rx_busy <= 1'b1;
            end
          end
          START: begin
            s_cnt <= s_cnt + 4'd1;
            if (s_cnt == 4'd15) begin
              if (!vote) begin
                state   <= DATA;
                bit_cnt <= 3'd0;
              end else begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end
          end
          DATA: begin
            s_cnt <= s_cnt + 4'd1;
            if (s_cnt == 4'd15) begin
              if (bit_cnt == 3'd7) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          STOP: begin
            s_cnt <= s_cnt + 4'd1;
            if (s_cnt == 4'd9) begin
              rx_out    <= shreg;
              frame_err <= ~vote_stop;
              rx_done   <= 1'b1;
              state     <= IDLE;
              rx_busy   <= 1'b0;
              s_cnt     <= 4'd0;
            end
          end
          default: begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 10 clk per oversample tick, 160 clk per bit,
// frames driven cycle by cycle with optional inversion windows for glitch cases.
module tb_uart_rx_os;

  localparam int FREQ = 1_600_000;
  localparam int BAUD = 10_000;
  localparam int OSR  = FREQ / (BAUD * 16);
  localparam int BIT  = 16 * OSR;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_out;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  int vectors     = 0;
  int miscompares = 0;

  int         cyc = 0;
  int         done_cnt = 0;
  int         busy_cyc = 0;
  logic [7:0] done_val [16];
  logic       done_fe  [16];
  int         done_t   [16];

  uart_rx_os #(.freq(FREQ), .baud_rate(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_out    (rx_out),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_busy) busy_cyc <= busy_cyc + 1;
    if (rx_done) begin
      if (done_cnt < 16) begin
        done_val[done_cnt] <= rx_out;
        done_fe[done_cnt]  <= frame_err;
        done_t[done_cnt]   <= cyc;
      end
      done_cnt <= done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // gl_len clk of inverted line starting gl_s clk into the frame
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int gl_s, input int gl_len);
    logic [9:0] bits;
    logic       v;
    bits = {stop_b, d, 1'b0};
    for (int c = 0; c < 10 * BIT; c++) begin
      v = bits[c / BIT];
      if (c >= gl_s && c < gl_s + gl_len) v = ~v;
      rx = v;
      @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  initial begin
    int d0;
    int b0;
    int gap;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_rx_out", rx_out, 8'h00);
    check("reset_rx_done", rx_done, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_rx_busy", rx_busy, 0);
    idle(2 * BIT);

    send_frame(8'h99, 1'b1, 0, 0);
    idle(2 * BIT);
    check("f99_done_cnt", done_cnt, 1);
    check("f99_rx_out", rx_out, 8'h99);
    check("f99_frame_err", frame_err, 0);
    check("f99_busy_after", rx_busy, 0);

    send_frame(8'hA5, 1'b1, 0, 0);
    send_frame(8'h3C, 1'b1, 0, 0);
    idle(2 * BIT);
    check("b2b_done_cnt", done_cnt, 3);
    check("b2b_first", done_val[1], 8'hA5);
    check("b2b_second", done_val[2], 8'h3C);
    check("b2b_fe", {done_fe[1], done_fe[2]}, 2'b00);
    gap = done_t[2] - done_t[1];
    check("b2b_spacing", (gap >= 10 * BIT - 10) && (gap <= 10 * BIT + 10), 1);

    d0 = done_cnt;
    b0 = busy_cyc;
    rx = 1'b0;
    repeat (3 * OSR) @(posedge clk);
    #1;
    idle(3 * BIT);
    check("glitch_busy_seen", busy_cyc > b0, 1);
    check("glitch_no_done", done_cnt, d0);
    check("glitch_rx_out", rx_out, 8'h3C);
    check("glitch_busy_low", rx_busy, 0);

    send_frame(8'h55, 1'b0, 0, 0);
    idle(2 * BIT);
    check("ferr_done_cnt", done_cnt, d0 + 1);
    check("ferr_rx_out", rx_out, 8'h55);
    check("ferr_flag", frame_err, 1);
    send_frame(8'h0F, 1'b1, 0, 0);
    idle(2 * BIT);
    check("ferr_clear_out", rx_out, 8'h0F);
    check("ferr_clear_flag", frame_err, 0);

    send_frame(8'hF0, 1'b1, 4 * BIT + BIT / 2 - 3, OSR);
    idle(2 * BIT);
    check("vote_mask", rx_out, 8'hF0);
    send_frame(8'hF0, 1'b1, 4 * BIT + BIT / 4, BIT / 2);
    idle(2 * BIT);
    check("vote_span", rx_out, 8'hF8);
    check("vote_span_fe", frame_err, 0);

    d0 = done_cnt;
    fork
      send_frame(8'hC3, 1'b1, 0, 0);
      begin
        repeat (5 * BIT + 40) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("rst_mid_busy", rx_busy, 0);
        check("rst_mid_rx_out", rx_out, 8'h00);
        check("rst_mid_fe", frame_err, 0);
      end
    join
    idle(OSR);
    rst = 1'b0;
    idle(2 * BIT);
    check("rst_no_done", done_cnt, d0);
    check("rst_rx_out_held", rx_out, 8'h00);
    send_frame(8'h7E, 1'b1, 0, 0);
    idle(2 * BIT);
    check("after_rst_done", done_cnt, d0 + 1);
    check("after_rst_rx_out", rx_out, 8'h7E);
    check("after_rst_fe", frame_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- 8N1 UART receiver using 16x oversampling; the receive-side partner of the team's uarttx transmitter, on the same clk/rst domain.
- Synchronises the serial line, validates the start bit, and majority-votes three mid-bit samples per bit.
- Presents the byte on a registered parallel output with a one-cycle done pulse and a framing-error flag.
- Sits between the board RX pin and the byte consumer (loopback bench, command parser).

Parameters:
- freq, 100_000_000, system clock frequency in Hz.
- baud_rate, 9600, line rate in bit/s.
- OSR_DIV (localparam) = freq/(baud_rate*16), integer division: clk cycles per oversample tick. Default 651.

Ports:
- clk  input  1  system clock; all logic on posedge clk.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_out  output  8  last received byte, LSB first on the line.
- rx_done  output  1  one-clk pulse when rx_out and frame_err update.
- frame_err  output  1  stop bit of the last completed frame sampled low.
- rx_busy  output  1  high while the FSM is outside IDLE.

Behaviour:
- Reset, asynchronous: rx_out=8'h00, rx_done=0, frame_err=0, rx_busy=0, FSM=IDLE, synchroniser flops=1, counters=0.
- Synchroniser: two-flop rx -> rx_s. All decisions use rx_s, so there are 2 clk of input latency.
- Tick generator: free-running counter 0..OSR_DIV-1. tick=1 for one clk when the counter reaches OSR_DIV-1, then the counter wraps to 0. Width is $clog2(OSR_DIV).
- FSM state changes occur only on tick clocks; rx_done is the only output pulsing independent of tick alignment (one clk wide).
- Sample counter s: 4 bits, 0..15, increments per tick in non-IDLE states, wraps 15->0. Bit counter: 3 bits.
- Majority: samples at s=7,8,9 are registered; vote = 2-of-3.
- IDLE: on a tick with rx_s=0 -> START, s=0. Otherwise stay.
- START: at s=15, if vote=0 -> DATA, bit counter=0; if vote=1 (glitch) -> IDLE, no outputs change.
- DATA: at s=15 the vote is shifted into the shift register MSB-side, right shift, so the first bit ends in bit 0. After bit 7 -> STOP; otherwise the bit counter increments.
- STOP: evaluate the vote at s=9, not 15, so a back-to-back start edge is never missed. On evaluation:
  - rx_out <= shift register.
  - frame_err <= ~vote.
  - rx_done pulses for one clk.
  - FSM -> IDLE.
- On a framing error, rx_out is still updated. No break or resync logic: after a frame error the FSM re-arms in IDLE and the next low starts a new frame.
- rx_out and frame_err hold until the next completed frame. frame_err clears on the next good frame.
- rx_busy = (state != IDLE), registered with the state.
- Latency: falling start edge to rx_done ≈ 16*9+10 = 154 ticks, +2 clk sync, +≤1 tick detection jitter.
- Back-to-back frames with one stop bit must all be received.
- Line held low continuously: a frame of 8'h00 with frame_err=1, then re-detection continues every ~154 ticks while low persists.
- Reset mid-frame: immediate return to reset values. A partial frame is discarded with no rx_done.

Test Plan:
- Send 8'h99 at 9600 baud (10416 clk/bit) -> exactly one rx_done pulse, rx_out=8'h99, frame_err=0, rx_busy low after the pulse.
- Back-to-back 8'hA5 then 8'h3C with one stop bit, no gap -> two rx_done pulses ~10 bit times apart, values A5 then 3C.
- rx low glitch of 3 ticks (~1953 clk) then high -> rx_busy pulses, no rx_done, rx_out unchanged.
- 8'h55 with stop bit driven 0 -> rx_done, rx_out=8'h55, frame_err=1; next good frame 8'h0F -> frame_err=0, rx_out=8'h0F.
- Frame 8'hF0 with data bit 3 inverted for one tick centred on s=8 -> rx_out=8'hF0 (majority masks it). Inversion spanning s=7..9 -> rx_out=8'hF8.
- Assert rst during data bit 4 of 8'hC3 -> outputs return to reset values, no rx_done; the following 8'h7E is received correctly.
